ym3438_out_mixer: RTL and testbench

- Downstream consumer of the per-channel output stage.
- Takes the 9-bit offset-binary channel sample once per channel slot, applies per-channel L/R pan and sums all 6 channels into signed stereo frame totals.
- Outputs a 12-bit signed L/R pair with a one-cycle valid strobe, which feeds the board-level audio mixer / resampler.

---
 rtl/ym3438_out_mixer.sv | 116 +++++++++++
 tb/tb_ym3438_out_mixer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ym3438_out_mixer.sv
// rtl/ym3438_out_mixer.sv - per-channel pan and stereo frame summing of YM3438 channel samples.
// Optional YM2612 DAC ladder crossover emulation is enabled by defining YM_LADDER_EN.
module ym3438_out_mixer #(
    parameter int NUM_CH = 6,
    parameter int OUT_W  = 12
) (
    input  logic                MCLK,
    input  logic                reset,
    input  logic                slot_en,
    input  logic                ch_valid,
    input  logic                frame_sync,
    input  logic [8:0]          ch_out,
    input  logic [2*NUM_CH-1:0] pan,
    output logic [OUT_W-1:0]    out_l,
    output logic [OUT_W-1:0]    out_r,
    output logic                out_valid,
    output logic [2:0]          slot_dbg
);

    localparam logic [2:0] LAST_SLOT = 3'(NUM_CH - 1);

    logic [2:0]              slot_q, slot_d;
    logic signed [OUT_W-1:0] acc_l_q, acc_l_d;
    logic signed [OUT_W-1:0] acc_r_q, acc_r_d;
    logic signed [OUT_W-1:0] out_l_q, out_l_d;
    logic signed [OUT_W-1:0] out_r_q, out_r_d;
    logic                    out_valid_q, out_valid_d;
    logic                    frame_seen_q, frame_seen_d;

    logic [2:0]              k;
    logic                    pan_l, pan_r;
    logic signed [OUT_W-1:0] s_ext;
    logic signed [OUT_W-1:0] add_l, add_r;
    logic signed [OUT_W-1:0] base_l, base_r;
    logic signed [OUT_W-1:0] sum_l, sum_r;
`ifdef YM_LADDER_EN
    logic signed [OUT_W-1:0] ofs;
`endif

    always_comb begin
        slot_d       = slot_q;
        acc_l_d      = acc_l_q;
        acc_r_d      = acc_r_q;
        out_l_d      = out_l_q;
        out_r_d      = out_r_q;
        out_valid_d  = 1'b0;
        frame_seen_d = frame_seen_q;

        // Offset binary to two's complement: flip the MSB, then sign-extend.
        s_ext  = {{(OUT_W-9){~ch_out[8]}}, ~ch_out[8], ch_out[7:0]};
        k      = frame_sync ? 3'd0 : slot_q;
        pan_l  = pan[{k, 1'b1}];
        pan_r  = pan[{k, 1'b0}];
        base_l = frame_sync ? '0 : acc_l_q;
        base_r = frame_sync ? '0 : acc_r_q;

`ifdef YM_LADDER_EN
        // The ladder offset lands on both sides, even when a side is panned off.
        ofs   = s_ext[OUT_W-1] ? -OUT_W'(4) : OUT_W'(4);
        add_l = ch_valid ? (pan_l ? s_ext + ofs : ofs) : '0;
        add_r = ch_valid ? (pan_r ? s_ext + ofs : ofs) : '0;
`else
        add_l = (ch_valid && pan_l) ? s_ext : '0;
        add_r = (ch_valid && pan_r) ? s_ext : '0;
`endif

        sum_l = base_l + add_l;
        sum_r = base_r + add_r;

        if (slot_en) begin
            if (frame_sync) begin
                frame_seen_d = 1'b1;
            end
            if (k == LAST_SLOT) begin
                slot_d  = 3'd0;
                acc_l_d = '0;
                acc_r_d = '0;
                if (frame_seen_q) begin
                    out_l_d     = sum_l;
                    out_r_d     = sum_r;
                    out_valid_d = 1'b1;
                end
            end else begin
                slot_d  = k + 3'd1;
                acc_l_d = sum_l;
                acc_r_d = sum_r;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            slot_q       <= 3'd0;
            acc_l_q      <= '0;
            acc_r_q      <= '0;
            out_l_q      <= '0;
            out_r_q      <= '0;
            out_valid_q  <= 1'b0;
            frame_seen_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            acc_l_q      <= acc_l_d;
            acc_r_q      <= acc_r_d;
            out_l_q      <= out_l_d;
            out_r_q      <= out_r_d;
            out_valid_q  <= out_valid_d;
            frame_seen_q <= frame_seen_d;
        end
    end

    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign out_valid = out_valid_q;
    assign slot_dbg  = slot_q;

endmodule

// File: tb/tb_ym3438_out_mixer.sv
// tb/tb_ym3438_out_mixer.sv - randomized and directed check of ym3438_out_mixer against a frame-level model.
module tb_ym3438_out_mixer;

    logic        MCLK = 1'b0;
    logic        reset = 1'b1;
    logic        slot_en = 1'b0;
    logic        ch_valid = 1'b0;
    logic        frame_sync = 1'b0;
    logic [8:0]  ch_out = 9'h100;
    logic [11:0] pan = 12'h000;
    logic [11:0] out_l, out_r;
    logic        out_valid;
    logic [2:0]  slot_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    ym3438_out_mixer dut (
        .MCLK(MCLK), .reset(reset), .slot_en(slot_en), .ch_valid(ch_valid),
        .frame_sync(frame_sync), .ch_out(ch_out), .pan(pan),
        .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .slot_dbg(slot_dbg)
    );

    always #5 MCLK = ~MCLK;

    // Model: contributions of the frame in progress are kept as lists and summed at frame end.
    int  m_slot = 0;
    bit  m_seen = 0;
    int  m_pl[$];
    int  m_pr[$];
    int  exp_l = 0, exp_r = 0, exp_slot = 0;
    bit  exp_valid = 0;
    bit  chk_en = 0;
    int  pulses = 0;

    function automatic int to_signed(logic [8:0] c);
        return c[8] ? int'(c[7:0]) : int'(c[7:0]) - 256;
    endfunction

    function automatic int contrib(int s, bit v, bit p);
        if (!v) return 0;
`ifdef YM_LADDER_EN
        return p ? s + ((s >= 0) ? 4 : -4) : ((s >= 0) ? 4 : -4);
`else
        return p ? s : 0;
`endif
    endfunction

    task automatic model_update();
        int k, sl, sr;
        exp_valid = 0;
        if (reset) begin
            m_slot = 0; m_seen = 0; m_pl.delete(); m_pr.delete();
            exp_l = 0; exp_r = 0;
        end else if (slot_en) begin
            if (frame_sync) begin
                m_pl.delete(); m_pr.delete(); m_seen = 1; k = 0;
            end else begin
                k = m_slot;
            end
            m_pl.push_back(contrib(to_signed(ch_out), ch_valid, pan[2*k+1]));
            m_pr.push_back(contrib(to_signed(ch_out), ch_valid, pan[2*k]));
            if (k == 5) begin
                if (m_seen) begin
                    sl = 0; sr = 0;
                    foreach (m_pl[i]) sl += m_pl[i];
                    foreach (m_pr[i]) sr += m_pr[i];
                    exp_l = sl; exp_r = sr; exp_valid = 1;
                end
                m_pl.delete(); m_pr.delete();
                m_slot = 0;
            end else begin
                m_slot = k + 1;
            end
        end
        exp_slot = m_slot;
    endtask

    task automatic chk(string name, integer got, integer want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge MCLK) begin
        if (chk_en) begin
            chk("out_valid", integer'(out_valid), integer'(exp_valid));
            chk("out_l", integer'($signed(out_l)), exp_l);
            chk("out_r", integer'($signed(out_r)), exp_r);
            chk("slot_dbg", integer'(slot_dbg), exp_slot);
            if (out_valid === 1'b1) pulses++;
        end
    end

    task automatic cyc();
        @(posedge MCLK);
        model_update();
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            slot_en = 0;
            frame_sync = 1'($urandom_range(0, 1));
            ch_out = 9'($urandom);
            pan = 12'($urandom);
            cyc();
        end
        frame_sync = 0;
    endtask

    task automatic accept(bit fs, bit v, logic [8:0] c, logic [11:0] p);
        slot_en = 1; frame_sync = fs; ch_valid = v; ch_out = c; pan = p;
        cyc();
        slot_en = 0; frame_sync = 0;
        idle($urandom_range(0, 2));
    endtask

    task automatic frame(bit fs, logic [8:0] c, logic [11:0] p);
        for (int i = 0; i < 6; i++) accept(fs && (i == 0), 1'b1, c, p);
        idle(2);
    endtask

    task automatic pulse_reset();
        reset = 1; cyc(); reset = 0;
    endtask

    int p0;

    initial begin
        cyc(); cyc();
        reset = 0;
        chk_en = 1;
        #2;
        chk("reset out_l", integer'($signed(out_l)), 0);
        chk("reset out_valid", integer'(out_valid), 0);
        chk("reset slot", integer'(slot_dbg), 0);

        p0 = pulses;
        frame(1'b0, 9'h1FF, 12'hFFF);
        chk("no pulse before first frame_sync", pulses - p0, 0);

        p0 = pulses;
        frame(1'b1, 9'h100, 12'hFFF);
        chk("zero frame pulses", pulses - p0, 1);
        chk("zero frame out_l", integer'($signed(out_l)), 0);

        frame(1'b1, 9'h1FF, 12'hFFF);
`ifdef YM_LADDER_EN
        chk("max frame out_l", integer'($signed(out_l)), 1554);
        chk("max frame model", exp_r, 1554);
`else
        chk("max frame out_l", integer'($signed(out_l)), 1530);
        chk("max frame model", exp_r, 1530);
`endif
        frame(1'b1, 9'h000, 12'hFFF);
`ifdef YM_LADDER_EN
        chk("min frame out_r", integer'($signed(out_r)), -1560);
`else
        chk("min frame out_r", integer'($signed(out_r)), -1536);
        chk("min frame raw", integer'(out_l), 12'hA00);
`endif

`ifndef YM_LADDER_EN
        frame(1'b1, 9'h164, 12'b10_01_00_11_10_01);
        chk("pan mix out_l", integer'($signed(out_l)), 300);
        chk("pan mix out_r", integer'($signed(out_r)), 300);
        frame(1'b1, 9'h164, 12'b00_01_00_11_10_01);
        chk("pan ch5 off out_l", integer'($signed(out_l)), 200);
        chk("pan ch5 off model", exp_r, 300);
`endif

        p0 = pulses;
        for (int i = 0; i < 3; i++) accept(i == 0, 1'b1, 9'h132, 12'hFFF);
        frame(1'b1, 9'h1FF, 12'hFFF);
        chk("partial frame pulses", pulses - p0, 1);
        chk("after partial out_l", integer'($signed(out_l)), exp_l);
`ifndef YM_LADDER_EN
        chk("after partial literal", exp_l, 1530);
`endif

        for (int i = 0; i < 4; i++) accept(i == 0, 1'b1, 9'h164, 12'hFFF);
        pulse_reset();
        #2;
        chk("mid reset out_valid", integer'(out_valid), 0);
        chk("mid reset out_l", integer'($signed(out_l)), 0);
        p0 = pulses;
        frame(1'b0, 9'h164, 12'hFFF);
        chk("no pulse after reset", pulses - p0, 0);
        frame(1'b1, 9'h164, 12'hFFF);
        chk("pulse after resync", pulses - p0, 1);

`ifdef YM_LADDER_EN
        frame(1'b1, 9'h100, 12'h000);
        chk("ladder silent out_l", integer'($signed(out_l)), 24);
        chk("ladder silent out_r", integer'($signed(out_r)), 24);
        frame(1'b1, 9'h0FF, 12'hFFF);
        chk("ladder minus one out_l", integer'($signed(out_l)), -30);
        chk("ladder minus one model", exp_r, -30);
`else
        frame(1'b1, 9'h0FF, 12'hFFF);
        chk("minus one out_l", integer'($signed(out_l)), -6);
`endif

        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) pulse_reset();
            else if (r < 10) idle(1);
            else if (r < 20) frame(1'b1, 9'($urandom), 12'($urandom));
            else accept($urandom_range(0, 15) == 0, $urandom_range(0, 4) != 0,
                        9'($urandom), 12'($urandom));
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
